// File: rtl/gcd_sweep_pkg.sv
// Shared constants for the GCD sweep sequencer: FSM encoding, default widths and
// the WAIT timeout.
package gcd_sweep_pkg;

    localparam int unsigned GcdW        = 8;
    localparam int unsigned CycW        = 16;
    localparam int unsigned TimeoutClks = 1000;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StStart = 3'd1;
    localparam state_t StWait  = 3'd2;
    localparam state_t StAck   = 3'd3;
    localparam state_t StNext  = 3'd4;
    localparam state_t StFin   = 3'd5;

endpackage

// File: rtl/gcd_sweep_stats.sv
// Sweep statistics: completed pair count, wrapping GCD sum and the worst-case
// latency together with the operands that produced it.
module gcd_sweep_stats
    import gcd_sweep_pkg::*;
#(
    parameter int unsigned W     = GcdW,
    parameter int unsigned CNT_W = CycW
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clear,
    input  logic             update,
    input  logic [CNT_W-1:0] cyc,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     gcd,
    output logic [2*W:0]     Pair_Count,
    output logic [3*W-1:0]   Gcd_Sum,
    output logic [CNT_W-1:0] Max_Cycles,
    output logic [W-1:0]     Max_A,
    output logic [W-1:0]     Max_B
);

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            Pair_Count <= '0;
            Gcd_Sum    <= '0;
            Max_Cycles <= '0;
            Max_A      <= '0;
            Max_B      <= '0;
        end else if (update) begin
            Pair_Count <= Pair_Count + 1'b1;
            Gcd_Sum    <= Gcd_Sum + {{(2*W){1'b0}}, gcd};
            // Strict compare so that ties keep the earliest pair.
            if (cyc > Max_Cycles) begin
                Max_Cycles <= cyc;
                Max_A      <= a;
                Max_B      <= b;
            end
        end
    end

endmodule

// File: rtl/gcd_sweep_sequencer.sv
// Walks every operand pair Lo..Hi (a-major) through an ee354_GCD core, handling
// the Start/Ack handshake and timing each computation for the stats block.
module gcd_sweep_sequencer
    import gcd_sweep_pkg::*;
#(
    parameter int unsigned W       = GcdW,
    parameter int unsigned CNT_W   = CycW,
    parameter int unsigned TIMEOUT = TimeoutClks
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             CEN,
    input  logic             Go,
    input  logic [W-1:0]     Lo,
    input  logic [W-1:0]     Hi,
    output logic [W-1:0]     Ain,
    output logic [W-1:0]     Bin,
    output logic             Start,
    output logic             Ack,
    input  logic             q_Done_in,
    input  logic [W-1:0]     AB_GCD_in,
    output logic             Busy,
    output logic             Sweep_Done,
    output logic             Timeout_Err,
    output logic [2*W:0]     Pair_Count,
    output logic [3*W-1:0]   Gcd_Sum,
    output logic [CNT_W-1:0] Max_Cycles,
    output logic [W-1:0]     Max_A,
    output logic [W-1:0]     Max_B
);

    state_t           state;
    logic [W-1:0]     lo_q;
    logic [W-1:0]     hi_q;
    logic [CNT_W-1:0] cyc;
    logic             stats_clear;
    logic             stats_update;

    assign Busy         = (state != StIdle);
    assign stats_clear  = CEN && (state == StIdle) && Go;
    assign stats_update = CEN && (state == StAck);

    // Ain/Bin double as the a/b sweep counters; they are loaded as START is entered
    // so the core sees valid operands alongside the Start pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= StIdle;
            lo_q        <= '0;
            hi_q        <= '0;
            Ain         <= '0;
            Bin         <= '0;
            Start       <= 1'b0;
            Ack         <= 1'b0;
            cyc         <= '0;
            Sweep_Done  <= 1'b0;
            Timeout_Err <= 1'b0;
        end else if (CEN) begin
            Start <= 1'b0;
            Ack   <= 1'b0;
            case (state)
                StIdle: begin
                    if (Go) begin
                        lo_q        <= Lo;
                        hi_q        <= Hi;
                        Ain         <= Lo;
                        Bin         <= Lo;
                        Sweep_Done  <= 1'b0;
                        Timeout_Err <= 1'b0;
                        if (Lo > Hi) begin
                            state <= StFin;
                        end else begin
                            state <= StStart;
                            Start <= 1'b1;
                        end
                    end
                end
                StStart: begin
                    cyc   <= '0;
                    state <= StWait;
                end
                StWait: begin
                    if (q_Done_in) begin
                        state <= StAck;
                        Ack   <= 1'b1;
                    end else if (cyc == CNT_W'(TIMEOUT)) begin
                        Timeout_Err <= 1'b1;
                        state       <= StFin;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                StAck: begin
                    state <= StNext;
                end
                StNext: begin
                    // Compare before incrementing so Hi = all-ones never wraps.
                    if (Bin != hi_q) begin
                        Bin   <= Bin + 1'b1;
                        state <= StStart;
                        Start <= 1'b1;
                    end else if (Ain != hi_q) begin
                        Ain   <= Ain + 1'b1;
                        Bin   <= lo_q;
                        state <= StStart;
                        Start <= 1'b1;
                    end else begin
                        state <= StFin;
                    end
                end
                StFin: begin
                    Sweep_Done <= 1'b1;
                    state      <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    gcd_sweep_stats #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_stats (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (stats_clear),
        .update     (stats_update),
        .cyc        (cyc),
        .a          (Ain),
        .b          (Bin),
        .gcd        (AB_GCD_in),
        .Pair_Count (Pair_Count),
        .Gcd_Sum    (Gcd_Sum),
        .Max_Cycles (Max_Cycles),
        .Max_A      (Max_A),
        .Max_B      (Max_B)
    );

endmodule

// File: tb/tb_gcd_sweep_sequencer.sv
// Directed bench for gcd_sweep_sequencer with a behavioural GCD core stub whose
// latency is selected per test.
module tb_gcd_sweep_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, CEN, Go;
    logic [7:0]  Lo, Hi, Ain, Bin, AB_GCD_in, Max_A, Max_B;
    logic        Start, Ack, q_Done_in, Busy, Sweep_Done, Timeout_Err;
    logic [16:0] Pair_Count;
    logic [23:0] Gcd_Sum;
    logic [15:0] Max_Cycles;

    always #5 Clk = ~Clk;

    gcd_sweep_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .CEN         (CEN),
        .Go          (Go),
        .Lo          (Lo),
        .Hi          (Hi),
        .Ain         (Ain),
        .Bin         (Bin),
        .Start       (Start),
        .Ack         (Ack),
        .q_Done_in   (q_Done_in),
        .AB_GCD_in   (AB_GCD_in),
        .Busy        (Busy),
        .Sweep_Done  (Sweep_Done),
        .Timeout_Err (Timeout_Err),
        .Pair_Count  (Pair_Count),
        .Gcd_Sum     (Gcd_Sum),
        .Max_Cycles  (Max_Cycles),
        .Max_A       (Max_A),
        .Max_B       (Max_B)
    );

    function automatic int gcd_fn(input int a, input int b);
        int x = a;
        int y = b;
        while (y != 0) begin
            int t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Stub latency: mode 0 -> a+b clocks, mode 1 -> (a+b)%5, mode 2 -> never done.
    function automatic int lat_of(input int a, input int b, input int mode);
        if (mode == 0) return a + b;
        if (mode == 1) return (a + b) % 5;
        return -1;
    endfunction

    int stub_mode = 0;
    int stub_lat;
    int stub_cnt;
    logic stub_busy;

    always_comb begin
        stub_lat  = lat_of(int'(Ain), int'(Bin), stub_mode);
        q_Done_in = stub_busy && (stub_lat >= 0) && (stub_cnt == stub_lat);
        AB_GCD_in = 8'(gcd_fn(int'(Ain), int'(Bin)));
    end

    always @(posedge Clk) begin
        if (Reset) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
        end else if (CEN) begin
            if (Start) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 0;
            end else if (Ack) begin
                stub_busy <= 1'b0;
            end else if (stub_busy && stub_cnt != stub_lat) begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    // Start/Ack monitor: every enabled clock with the pulse high counts once.
    logic [15:0] start_q[$];
    int ack_cnt = 0;
    always @(posedge Clk) begin
        if (!Reset && CEN && Start) start_q.push_back({Ain, Bin});
        if (!Reset && CEN && Ack) ack_cnt <= ack_cnt + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic run_sweep(input logic [7:0] lo, input logic [7:0] hi, input int mode,
                             input int budget, output int clks);
        stub_mode = mode;
        Lo = lo;
        Hi = hi;
        Go = 1'b1;
        tick(1);
        Go = 1'b0;
        clks = 0;
        while (!Sweep_Done && clks < budget) begin
            tick(1);
            clks++;
        end
        if (!Sweep_Done) check("sweep_bound", 64'(Sweep_Done), 64'd1);
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_ain"}, 64'(Ain), 64'd0);
        check({tag, "_bin"}, 64'(Bin), 64'd0);
        check({tag, "_start_ack"}, 64'({Start, Ack}), 64'd0);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_flags"}, 64'({Sweep_Done, Timeout_Err}), 64'd0);
        check({tag, "_pairs"}, 64'(Pair_Count), 64'd0);
        check({tag, "_sum"}, 64'(Gcd_Sum), 64'd0);
        check({tag, "_max"}, 64'({Max_Cycles, Max_A, Max_B}), 64'd0);
    endtask

    initial begin
        int clks, s0, a0, exp_sum;
        logic [15:0] exp_pairs[4];
        logic [7:0] held_a, held_b;
        exp_pairs[0] = 16'h0202;
        exp_pairs[1] = 16'h0203;
        exp_pairs[2] = 16'h0302;
        exp_pairs[3] = 16'h0303;

        Reset = 1'b1;
        CEN   = 1'b1;
        Go    = 1'b0;
        Lo    = '0;
        Hi    = '0;
        tick(2);
        check_zero_outs("reset");
        Reset = 1'b0;
        tick(1);

        // Small sweep with latency a+b: cyc 4,5,5,6 -> 20 + 4*4 pair clocks + FIN.
        s0 = start_q.size();
        a0 = ack_cnt;
        run_sweep(8'd2, 8'd3, 0, 200, clks);
        check("t1_starts", 64'(start_q.size() - s0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (s0 + i < start_q.size()) check("t1_pair", 64'(start_q[s0 + i]), 64'(exp_pairs[i]));
        end
        check("t1_acks", 64'(ack_cnt - a0), 64'd4);
        check("t1_pairs", 64'(Pair_Count), 64'd4);
        check("t1_sum", 64'(Gcd_Sum), 64'd7);
        check("t1_maxcyc", 64'(Max_Cycles), 64'd6);
        check("t1_maxab", 64'({Max_A, Max_B}), 64'h0303);
        check("t1_done", 64'({Sweep_Done, Timeout_Err, Busy}), 64'b100);
        check("t1_clocks", 64'(clks), 64'd37);

        // Full 2..63 sweep; latency (a+b)%5 first peaks at 4 on pair (2,2).
        exp_sum = 0;
        for (int a = 2; a <= 63; a++)
            for (int b = 2; b <= 63; b++) exp_sum += gcd_fn(a, b);
        s0 = start_q.size();
        run_sweep(8'd2, 8'd63, 1, 60000, clks);
        check("t2_pairs", 64'(Pair_Count), 64'd3844);
        check("t2_starts", 64'(start_q.size() - s0), 64'd3844);
        check("t2_sum", 64'(Gcd_Sum), 64'(exp_sum & 24'hFFFFFF));
        check("t2_maxcyc", 64'(Max_Cycles), 64'd4);
        check("t2_maxab", 64'({Max_A, Max_B}), 64'h0202);
        check("t2_last", 64'(start_q[start_q.size() - 1]), 64'h3F3F);
        check("t2_flags", 64'({Sweep_Done, Timeout_Err}), 64'b10);

        // Empty sweep: Go clock goes to FIN, the next clock finishes.
        s0 = start_q.size();
        run_sweep(8'd5, 8'd4, 0, 20, clks);
        check("t3_clocks", 64'(clks), 64'd1);
        check("t3_pairs", 64'(Pair_Count), 64'd0);
        check("t3_starts", 64'(start_q.size() - s0), 64'd0);
        check("t3_done", 64'({Sweep_Done, Busy}), 64'b10);

        // Top-of-range single pair; latency 0 never beats the cleared max.
        s0 = start_q.size();
        run_sweep(8'd255, 8'd255, 1, 50, clks);
        check("t4_pairs", 64'(Pair_Count), 64'd1);
        check("t4_sum", 64'(Gcd_Sum), 64'd255);
        check("t4_starts", 64'(start_q.size() - s0), 64'd1);
        if (start_q.size() > s0) check("t4_pair", 64'(start_q[s0]), 64'hFFFF);
        check("t4_maxcyc", 64'(Max_Cycles), 64'd0);
        check("t4_done", 64'({Sweep_Done, Busy}), 64'b10);

        // Core never finishes: START, 1001 WAIT clocks, FIN.
        a0 = ack_cnt;
        run_sweep(8'd2, 8'd3, 2, 1500, clks);
        check("t5_clocks", 64'(clks), 64'd1003);
        check("t5_flags", 64'({Sweep_Done, Timeout_Err, Busy}), 64'b110);
        check("t5_acks", 64'(ack_cnt - a0), 64'd0);
        check("t5_pairs", 64'(Pair_Count), 64'd0);

        // CEN hold inside WAIT must not advance cyc: latency stays a+b = 4.
        stub_mode = 0;
        Lo = 8'd2;
        Hi = 8'd2;
        Go = 1'b1;
        tick(1);
        Go = 1'b0;
        tick(3);
        held_a = Ain;
        held_b = Bin;
        CEN = 1'b0;
        tick(7);
        check("t6_hold_ab", 64'({Ain, Bin}), 64'({held_a, held_b}));
        check("t6_hold_ctl", 64'({Busy, Start, Ack, Sweep_Done}), 64'b1000);
        CEN = 1'b1;
        clks = 0;
        while (!Sweep_Done && clks < 50) begin
            tick(1);
            clks++;
        end
        check("t6_maxcyc", 64'(Max_Cycles), 64'd4);
        check("t6_pairs", 64'(Pair_Count), 64'd1);

        // Reset mid-sweep, with CEN low to show Reset still wins.
        Lo = 8'd2;
        Hi = 8'd3;
        Go = 1'b1;
        tick(1);
        Go = 1'b0;
        tick(12);
        check("t7_busy_pre", 64'(Busy), 64'd1);
        CEN   = 1'b0;
        Reset = 1'b1;
        tick(1);
        check_zero_outs("t7_reset");
        Reset = 1'b0;
        CEN   = 1'b1;
        tick(3);
        check("t7_idle", 64'({Busy, Start}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_sweep_sequencer.md
Name: gcd_sweep_sequencer

Overview:
Upstream driver for the ee354_GCD core. It walks every operand pair (a,b) with Lo<=a,b<=Hi through the core and drives Ain/Bin, Start and Ack. It measures the clocks per computation and accumulates sweep statistics (pair count, GCD sum, worst-case latency and its operands). This gives an on-chip replacement for the exhaustive simulation sweep that board tests can read out.

Parameters:
W, 8, operand/GCD width
CNT_W, 16, per-pair cycle counter width
TIMEOUT, 1000, max WAIT clocks before abort (must be < 2^CNT_W)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
CEN  in  1  clock enable; when 0, all registers hold
Go  in  1  start sweep (sampled in IDLE only)
Lo  in  W  lower operand bound (latched on Go)
Hi  in  W  upper operand bound (latched on Go)
Ain  out  W  operand A to GCD core (registered)
Bin  out  W  operand B to GCD core (registered)
Start  out  1  one-clock start pulse to core
Ack  out  1  one-clock ack pulse to core
q_Done_in  in  1  core done-state flag
AB_GCD_in  in  W  core result
Busy  out  1  sweep in progress
Sweep_Done  out  1  sticky: last sweep completed or aborted
Timeout_Err  out  1  sticky: last sweep aborted by timeout
Pair_Count  out  2W+1  pairs completed
Gcd_Sum  out  3W  sum of results, wraps mod 2^(3W)
Max_Cycles  out  CNT_W  worst WAIT clocks seen
Max_A, Max_B  out  W each  operands of worst case

Behaviour:
- Reset: state IDLE. All outputs 0. Reset overrides CEN.
- CEN=0: no state or register change. Start/Ack hold their current values.
- States: IDLE, START, WAIT, ACK, NEXT, FIN. One transition per enabled clock.
- IDLE: Busy=0. On Go=1:
  - latch Lo/Hi; a<=Lo, b<=Lo; clear the stats and Sweep_Done/Timeout_Err.
  - if Lo>Hi go to FIN (empty sweep), else go to START.
- START: Ain=a, Bin=b; Start=1 for exactly this state's clock; cyc<=0; go to WAIT.
- Ain/Bin are stable from START through ACK.
- WAIT:
  - q_Done_in=1: go to ACK, cyc frozen.
  - else cyc++.
  - cyc==TIMEOUT: set Timeout_Err, go to FIN with no Ack, stats unchanged.
- ACK: Ack=1 for one clock; Pair_Count++; Gcd_Sum+=AB_GCD_in. If cyc>Max_Cycles (strict, so ties keep the earliest pair), load Max_Cycles/Max_A/Max_B. Go to NEXT.
- NEXT: order is a-major, b-minor.
  - b!=Hi: b++.
  - b==Hi and a!=Hi: a++, b<=Lo.
  - both ==Hi: go to FIN.
  - Comparison happens before increment, so Hi=2^W-1 never wraps.
  - Otherwise go to START.
- FIN: set Sweep_Done; go to IDLE. Stats hold until the next Go.
- Go while Busy is ignored.
- Busy=1 in all states except IDLE.
- Reset mid-sweep: immediate return to IDLE with Start=Ack=0. The core is reset by the same Reset.
- Pair latency: START(1)+WAIT(cyc+1)+ACK(1)+NEXT(1) clocks.

Decomposition:
- Package gcd_sweep_pkg: state enum/encoding, default widths, TIMEOUT constant.
- Sub-module gcd_sweep_stats: Pair_Count/Gcd_Sum/max-tracking registers. Inputs: clear, update strobe, cyc, a, b, gcd.
- The FSM and operand counters stay in the top module.

Test Plan:
- Stub core, Done after (a+b) clocks, Lo=2, Hi=3 -> Start pulses with (2,2),(2,3),(3,2),(3,3); Pair_Count=4; Gcd_Sum=7; Max_A=3, Max_B=3; Sweep_Done=1.
- Real ee354_GCD, Lo=2, Hi=63 -> Pair_Count=3844; Gcd_Sum matches a software model; Timeout_Err=0.
- Lo=5, Hi=4 -> FIN two clocks after Go; Pair_Count=0; no Start pulse; Sweep_Done=1.
- Lo=Hi=255 -> exactly one pair (255,255); Gcd_Sum=255; sweep terminates (no wrap).
- Stub never asserts Done -> Timeout_Err=1 after 1000 WAIT clocks; Ack never pulses; Busy drops.
- Hold CEN=0 for 7 clocks during WAIT, then Reset mid-sweep -> cyc and outputs frozen during the hold; after Reset all outputs are 0 and state is IDLE.
